avalon_debug_fifo: RTL and testbench



---
 rtl/avalon_debug_fifo.sv | 272 +++++++++++++++++++++++++++
 tb/tb_avalon_debug_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_debug_fifo.sv
// Avalon-MM debug/console bridge: CPU-written TX FIFO drained on a stream,
// stream-filled RX FIFO read by the CPU, with thresholds, IRQ and flush.
module avalon_debug_fifo #(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 6,
  parameter int RX_DROP    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        av_address,
  input  logic              av_chipselect,
  input  logic              av_read_n,
  input  logic              av_write_n,
  input  logic [31:0]       av_writedata,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic              av_irq,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              dataavailable,
  output logic              readyfordata
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;
  localparam int PW    = LOG2_DEPTH;

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] TXTH_C = CW'(DEPTH / 8);

  logic [DATA_W-1:0] r_tx_mem [DEPTH];
  logic [DATA_W-1:0] r_rx_mem [DEPTH];

  logic [PW-1:0] r_tx_wp;
  logic [PW-1:0] r_tx_rp;
  logic [PW-1:0] r_rx_wp;
  logic [PW-1:0] r_rx_rp;
  logic [CW-1:0] r_tx_cnt;
  logic [CW-1:0] r_rx_cnt;
  logic [CW-1:0] r_rx_th;
  logic [CW-1:0] r_tx_th;

  logic        r_ien_rx;
  logic        r_ien_tx;
  logic        r_ien_ovf;
  logic        r_wovf;
  logic        r_rovf;
  logic        r_wait;
  logic        r_irq;
  logic        r_da;
  logic        r_rfd;
  logic [31:0] r_rdata;

  logic        w_acc;
  logic        w_rd;
  logic        w_wr;
  logic        w_a0;
  logic        w_a1;
  logic        w_a2;
  logic        w_a3;
  logic        w_tx_empty;
  logic        w_tx_full;
  logic        w_rx_empty;
  logic        w_rx_full;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_wovf_set;
  logic        w_rovf_set;
  logic        w_st_wr;
  logic        w_tx_flush;
  logic        w_rx_flush;
  logic        w_rx_pend;
  logic        w_tx_pend;
  logic        w_ovf_pend;
  logic [CW-1:0] w_tx_free;
  logic [CW-1:0] w_rx_th_in;
  logic [CW-1:0] w_tx_th_in;
  logic [DATA_W-1:0] w_rx_head;
  logic [31:0] w_rdata;
  logic        w_unused;

  function automatic logic [CW-1:0] clamp(
    input logic [CW-1:0] v
  );
    return (v > FULL_C) ? FULL_C : v;
  endfunction

  assign w_acc = av_chipselect & r_wait
               & (~av_read_n | ~av_write_n);
  assign w_rd  = w_acc & ~av_read_n;
  assign w_wr  = w_acc & av_read_n & ~av_write_n;

  assign w_a0 = (av_address == 2'd0);
  assign w_a1 = (av_address == 2'd1);
  assign w_a2 = (av_address == 2'd2);
  assign w_a3 = (av_address == 2'd3);

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_C);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_C);

  // full/empty use start-of-cycle counts, so a same-cycle
  // pop never rescues a write into a full FIFO
  assign w_tx_push  = w_wr & w_a0 & ~w_tx_full;
  assign w_wovf_set = w_wr & w_a0 & w_tx_full;
  assign w_tx_pop   = ~w_tx_empty & tx_ready;
  assign w_rx_push  = rx_valid & ~w_rx_full;
  assign w_rx_pop   = w_rd & w_a0 & ~w_rx_empty;
  assign w_rovf_set = (RX_DROP != 0) && rx_valid
                   && w_rx_full;

  assign w_st_wr    = w_wr & w_a3;
  assign w_tx_flush = w_st_wr & av_writedata[8];
  assign w_rx_flush = w_st_wr & av_writedata[9];

  assign w_rx_pend  = (r_rx_cnt >= r_rx_th);
  assign w_tx_pend  = (r_tx_cnt <= r_tx_th);
  assign w_ovf_pend = r_wovf | r_rovf;

  assign w_tx_free  = FULL_C - r_tx_cnt;
  assign w_rx_th_in = av_writedata[LOG2_DEPTH:0];
  assign w_tx_th_in = av_writedata[16+LOG2_DEPTH:16];
  assign w_rx_head  = r_rx_mem[r_rx_rp];
  assign w_unused   = ^av_writedata;

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_a0: begin
        if (!w_rx_empty)
          w_rdata[DATA_W-1:0] = w_rx_head;
        w_rdata[15]    = ~w_rx_empty;
        w_rdata[31:16] = 16'(r_rx_cnt);
      end
      w_a1: begin
        w_rdata[2:0]  = {r_ien_ovf, r_ien_tx,
                         r_ien_rx};
        w_rdata[10:8] = {w_ovf_pend, w_tx_pend,
                         w_rx_pend};
      end
      w_a2: begin
        w_rdata[LOG2_DEPTH:0]        = r_rx_th;
        w_rdata[16+LOG2_DEPTH:16]    = r_tx_th;
      end
      w_a3: begin
        w_rdata[5:0]   = {r_rovf, r_wovf,
                          w_rx_full, w_rx_empty,
                          w_tx_full, w_tx_empty};
        w_rdata[31:16] = 16'(w_tx_free);
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait    <= 1'b1;
      r_rdata   <= '0;
      r_ien_rx  <= 1'b0;
      r_ien_tx  <= 1'b0;
      r_ien_ovf <= 1'b0;
      r_rx_th   <= CW'(1);
      r_tx_th   <= TXTH_C;
    end else begin
      if (w_acc) begin
        r_wait  <= 1'b0;
        r_rdata <= w_rd ? w_rdata : '0;
      end else begin
        r_wait  <= 1'b1;
      end
      if (w_wr && w_a1) begin
        r_ien_rx  <= av_writedata[0];
        r_ien_tx  <= av_writedata[1];
        r_ien_ovf <= av_writedata[2];
      end
      if (w_wr && w_a2) begin
        r_rx_th <= clamp(w_rx_th_in);
        r_tx_th <= clamp(w_tx_th_in);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wovf <= 1'b0;
      r_rovf <= 1'b0;
    end else begin
      if (w_wovf_set)
        r_wovf <= 1'b1;
      else if (w_st_wr && av_writedata[4])
        r_wovf <= 1'b0;
      if (w_rovf_set)
        r_rovf <= 1'b1;
      else if (w_st_wr && av_writedata[5])
        r_rovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_tx_push)
      r_tx_mem[r_tx_wp] <= av_writedata[DATA_W-1:0];
    if (w_rx_push)
      r_rx_mem[r_rx_wp] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst || w_tx_flush) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push)
        r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)
        r_tx_rp <= r_tx_rp + 1'b1;
      unique case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_rx_flush) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push)
        r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)
        r_rx_rp <= r_rx_rp + 1'b1;
      unique case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
      r_da  <= 1'b0;
      r_rfd <= 1'b0;
    end else begin
      r_irq <= |({r_ien_ovf, r_ien_tx, r_ien_rx}
               & {w_ovf_pend, w_tx_pend, w_rx_pend});
      r_da  <= ~w_rx_empty;
      r_rfd <= ~w_tx_full;
    end
  end

  assign av_readdata    = r_rdata;
  assign av_waitrequest = r_wait;
  assign av_irq         = r_irq;
  assign dataavailable  = r_da;
  assign readyfordata   = r_rfd;
  assign tx_data        = r_tx_mem[r_tx_rp];
  assign tx_valid       = ~w_tx_empty;
  assign rx_ready       = (RX_DROP != 0) ? 1'b1
                                         : ~w_rx_full;

endmodule

// File: tb/tb_avalon_debug_fifo.sv
// Scoreboard bench: two bridges (backpressure RX and drop-on-full RX)
// on shared Avalon and stream inputs with separate selects/valids.
`timescale 1ns/1ps
module tb_avalon_debug_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  av_address;
  logic        cs0, cs1;
  logic        av_read_n, av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] rdata0, rdata1;
  logic        wait0, wait1, irq0, irq1;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1, tx_ready;
  logic [7:0]  rx_data;
  logic        rxv0, rxv1, rx_ready0, rx_ready1;
  logic        da0, da1, rfd0, rfd1;

  avalon_debug_fifo #(.DATA_W(8), .LOG2_DEPTH(6),
                      .RX_DROP(0)) u_dut (
    .clk(clk), .rst(rst), .av_address(av_address),
    .av_chipselect(cs0), .av_read_n(av_read_n),
    .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(rdata0), .av_waitrequest(wait0),
    .av_irq(irq0), .tx_data(tx_data0),
    .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rxv0),
    .rx_ready(rx_ready0), .dataavailable(da0),
    .readyfordata(rfd0));

  avalon_debug_fifo #(.DATA_W(8), .LOG2_DEPTH(6),
                      .RX_DROP(1)) u_drop (
    .clk(clk), .rst(rst), .av_address(av_address),
    .av_chipselect(cs1), .av_read_n(av_read_n),
    .av_write_n(av_write_n), .av_writedata(av_writedata),
    .av_readdata(rdata1), .av_waitrequest(wait1),
    .av_irq(irq1), .tx_data(tx_data1),
    .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rxv1),
    .rx_ready(rx_ready1), .dataavailable(da1),
    .readyfordata(rfd1));

  typedef struct {
    logic [31:0] exp;
    string       name;
    bit          chk;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] txq[$];
  exp_t       e0, e1;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected event",
             name);
  endtask

  // monitor: sample just after the falling edge
  always @(negedge clk) begin
    #1;
    if (!wait0) begin
      if (q0.size() == 0) fail_now("av0_extra");
      else begin
        e0 = q0.pop_front();
        if (e0.chk) check(e0.name, rdata0, e0.exp);
      end
    end
    if (!wait1) begin
      if (q1.size() == 0) fail_now("av1_extra");
      else begin
        e1 = q1.pop_front();
        if (e1.chk) check(e1.name, rdata1, e1.exp);
      end
    end
    if (tx_valid0 && tx_ready) begin
      if (txq.size() == 0) fail_now("tx_extra");
      else check("tx_data", 32'(tx_data0),
                 32'(txq.pop_front()));
    end
  end

  task automatic acc(input int d, input bit wr,
                     input logic [1:0] a,
                     input logic [31:0] wd,
                     input logic [31:0] exp,
                     input string name, input bit chk);
    int   n = 0;
    exp_t e;
    while (((d == 0) ? wait0 : wait1) !== 1'b1
           && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) fail_now({name, "_wait"});
    e.exp  = exp;
    e.name = name;
    e.chk  = chk;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    av_address   = a;
    av_writedata = wd;
    av_read_n    = wr;
    av_write_n   = ~wr;
    if (d == 0) cs0 = 1'b1;
    else        cs1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cs0        = 1'b0;
    cs1        = 1'b0;
    av_read_n  = 1'b1;
    av_write_n = 1'b1;
  endtask

  task automatic rd(input int d, input logic [1:0] a,
                    input logic [31:0] exp,
                    input string name);
    acc(d, 1'b0, a, 32'h0, exp, name, 1'b1);
  endtask

  task automatic wr(input int d, input logic [1:0] a,
                    input logic [31:0] wd);
    acc(d, 1'b1, a, wd, 32'h0, "wr", 1'b0);
  endtask

  task automatic rx_stream(input int d, input int n,
                           input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      rx_data = 8'(base + 8'(i));
      if (d == 0) rxv0 = 1'b1;
      else        rxv1 = 1'b1;
      @(negedge clk);
    end
    rxv0 = 1'b0;
    rxv1 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    tx_ready = 1'b1;
    while (txq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tx_ready = 1'b0;
    if (n >= 300) fail_now("tx_drain");
  endtask

  initial begin
    rst = 1'b1;
    cs0 = 1'b0;
    cs1 = 1'b0;
    av_address = 2'd0;
    av_read_n = 1'b1;
    av_write_n = 1'b1;
    av_writedata = 32'h0;
    tx_ready = 1'b0;
    rx_data = 8'h0;
    rxv0 = 1'b0;
    rxv1 = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_wait", 32'(wait0), 32'd1);
    check("rst_rdata", rdata0, 32'h0);
    check("rst_irq", 32'(irq0), 32'd0);
    check("rst_da", 32'(da0), 32'd0);
    check("rst_rfd", 32'(rfd0), 32'd0);
    check("rst_txv", 32'(tx_valid0), 32'd0);
    check("rst_rxr", 32'(rx_ready0), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rfd", 32'(rfd0), 32'd1);

    rd(0, 2'd2, 32'h0008_0001, "def_thresh");
    rd(0, 2'd3, 32'h0040_0005, "def_status");
    rd(0, 2'd1, 32'h0000_0200, "def_ctrl");
    check("def_irq", 32'(irq0), 32'd0);

    for (int i = 0; i < 65; i++) begin
      if (i < 64) txq.push_back(8'(i));
      wr(0, 2'd0, 32'(i));
    end
    @(negedge clk);
    check("full_rfd", 32'(rfd0), 32'd0);
    rd(0, 2'd3, 32'h0000_0016, "full_status");
    drain();
    check("drain_txv", 32'(tx_valid0), 32'd0);
    rd(0, 2'd3, 32'h0040_0015, "drain_status");
    wr(0, 2'd3, 32'h10);
    rd(0, 2'd3, 32'h0040_0005, "wovf_clr");

    wr(0, 2'd2, 32'h0008_0003);
    wr(0, 2'd1, 32'h1);
    rx_stream(0, 3, 8'hA1);
    check("irq_early", 32'(irq0), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irq0), 32'd1);
    rd(0, 2'd0, 32'h0003_80A1, "rx_rd1");
    rd(0, 2'd0, 32'h0002_80A2, "rx_rd2");
    rd(0, 2'd0, 32'h0001_80A3, "rx_rd3");
    rd(0, 2'd0, 32'h0000_0000, "rx_rd_empty");
    check("irq_fall", 32'(irq0), 32'd0);
    wr(0, 2'd2, 32'h00FF_00FF);
    rd(0, 2'd2, 32'h0040_0040, "th_clamp");
    wr(0, 2'd2, 32'h0);
    rd(0, 2'd1, 32'h0000_0301, "th_zero");
    check("th_zero_irq", 32'(irq0), 32'd1);
    wr(0, 2'd1, 32'h0);
    wr(0, 2'd2, 32'h0008_0001);

    rx_stream(0, 64, 8'h00);
    check("rx_bp_ready", 32'(rx_ready0), 32'd0);
    rx_stream(0, 2, 8'hF0);
    check("rx_bp_da", 32'(da0), 32'd1);
    rd(0, 2'd3, 32'h0040_0009, "rx_bp_status");
    rd(0, 2'd0, 32'h0040_8000, "rx_bp_head");
    wr(0, 2'd3, 32'h200);
    rd(0, 2'd3, 32'h0040_0005, "rx_flushed");

    rx_stream(0, 10, 8'h50);
    rx_data = 8'h77;
    rxv0 = 1'b1;
    wr(0, 2'd3, 32'h200);
    rxv0 = 1'b0;
    check("flush_da_hold", 32'(da0), 32'd1);
    @(negedge clk);
    check("flush_da", 32'(da0), 32'd0);
    rd(0, 2'd0, 32'h0000_0000, "flush_cnt");
    rx_stream(0, 1, 8'h33);
    rd(0, 2'd0, 32'h0001_8033, "post_flush");

    for (int i = 0; i < 64; i++) begin
      txq.push_back(8'(8'h80 + 8'(i)));
      wr(0, 2'd0, 32'(8'h80 + 8'(i)));
    end
    @(negedge clk);
    tx_ready = 1'b1;
    wr(0, 2'd0, 32'hEE);
    tx_ready = 1'b0;
    rd(0, 2'd3, 32'h0001_0014, "sim_status");
    drain();
    check("sim_txv", 32'(tx_valid0), 32'd0);
    wr(0, 2'd3, 32'h10);
    rd(0, 2'd3, 32'h0040_0005, "sim_clr");

    wr(0, 2'd1, 32'h2);
    @(negedge clk);
    check("irq_tx", 32'(irq0), 32'd1);
    wr(0, 2'd1, 32'h4);
    @(negedge clk);
    check("irq_ovf_off", 32'(irq0), 32'd0);
    wr(0, 2'd1, 32'h0);

    rx_stream(1, 64, 8'h00);
    check("drop_ready_full", 32'(rx_ready1), 32'd1);
    rx_stream(1, 2, 8'hF0);
    check("drop_ready", 32'(rx_ready1), 32'd1);
    rd(1, 2'd3, 32'h0040_0029, "drop_status");
    rd(1, 2'd0, 32'h0040_8000, "drop_head");
    wr(1, 2'd3, 32'h20);
    rd(1, 2'd3, 32'h0040_0001, "drop_clr");

    repeat (3) @(negedge clk);
    check("q0_left", 32'(q0.size()), 32'd0);
    check("q1_left", 32'(q1.size()), 32'd0);
    check("txq_left", 32'(txq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
